// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: divider-paced digit scan with
// frame-aligned shadow loading, leading-zero suppression, blinking and polarity.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS      = 6,
    parameter int DIV             = 50000,
    parameter int BLINK_FRAMES    = 64,
    parameter int SEG_ACTIVE_HIGH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] code,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    code_load,
    input  logic                    lz_en,
    output logic [7:0]              digit_seg,
    output logic [NUM_DIGITS-1:0]   digit_cath,
    output logic                    frame_start,
    output logic                    load_ack
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = 8'hFC;
            4'h1:    s = 8'h60;
            4'h2:    s = 8'hDA;
            4'h3:    s = 8'hF2;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'hB6;
            4'h6:    s = 8'hBE;
            4'h7:    s = 8'hE0;
            4'h8:    s = 8'hFE;
            4'h9:    s = 8'hF6;
            4'hA:    s = 8'hEE;
            4'hB:    s = 8'h3E;
            4'hC:    s = 8'h9C;
            4'hD:    s = 8'h7A;
            4'hE:    s = 8'h9E;
            4'hF:    s = 8'h8E;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_code_q, sh_code_d, act_code_q, act_code_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
    logic                    pend_q, pend_d;
    logic [FRM_W-1:0]        frm_q, frm_d;
    logic                    phase_q, phase_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   cath_q, cath_d;
    logic                    fs_q, fs_d, ack_q, ack_d;

    logic                    tick_s, wrap_s, sel_s, higher_zero_s, lz_blank_s;
    logic                    dp_sel_s, blink_sel_s;
    logic [3:0]              nib_s;
    logic [7:0]              seg_raw_s;

    // Next-state logic; segment outputs are built from next-state index and
    // active data so a newly applied load is already visible on digit 0.
    always_comb begin
        div_d       = div_q;
        idx_d       = idx_q;
        sh_code_d   = sh_code_q;
        sh_dp_d     = sh_dp_q;
        sh_blink_d  = sh_blink_q;
        act_code_d  = act_code_q;
        act_dp_d    = act_dp_q;
        act_blink_d = act_blink_q;
        pend_d      = pend_q;
        frm_d       = frm_q;
        phase_d     = phase_q;
        seg_d       = seg_q;
        cath_d      = cath_q;

        tick_s = (div_q == DIV_W'(DIV - 1));
        wrap_s = tick_s && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (tick_s) begin
            div_d = '0;
            if (wrap_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (wrap_s && pend_q) begin
            act_code_d  = sh_code_q;
            act_dp_d    = sh_dp_q;
            act_blink_d = sh_blink_q;
            pend_d      = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // A load in the wrap cycle lands in the shadow and stays pending.
        if (code_load) begin
            sh_code_d  = code;
            sh_dp_d    = dp;
            sh_blink_d = blink_mask;
            pend_d     = 1'b1;
        end else begin
            sh_code_d = sh_code_q;
        end

        if (wrap_s) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end else begin
            frm_d = frm_q;
        end

        nib_s         = 4'h0;
        dp_sel_s      = 1'b0;
        blink_sel_s   = 1'b0;
        lz_blank_s    = 1'b0;
        higher_zero_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            sel_s         = (IDX_W'(i) == idx_d);
            higher_zero_s = higher_zero_s & (act_code_d[4*i +: 4] == 4'h0);
            nib_s         = nib_s | ({4{sel_s}} & act_code_d[4*i +: 4]);
            dp_sel_s      = dp_sel_s | (sel_s & act_dp_d[i]);
            blink_sel_s   = blink_sel_s | (sel_s & act_blink_d[i]);
            lz_blank_s    = lz_blank_s | (sel_s & lz_en & (i != 0) & higher_zero_s);
        end

        seg_raw_s = hex_to_seg(nib_s) | {7'b0000000, dp_sel_s};
        if (lz_blank_s || (!phase_d && blink_sel_s)) begin
            seg_raw_s = 8'h00;
        end else begin
            seg_raw_s = seg_raw_s;
        end

        if (tick_s) begin
            seg_d  = (SEG_ACTIVE_HIGH != 0) ? seg_raw_s : ~seg_raw_s;
            cath_d = ~(NUM_DIGITS'(1) << idx_d);
        end else begin
            seg_d  = seg_q;
            cath_d = cath_q;
        end

        fs_d  = wrap_s;
        ack_d = wrap_s && pend_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            sh_code_q   <= '0;
            sh_dp_q     <= '0;
            sh_blink_q  <= '0;
            act_code_q  <= '0;
            act_dp_q    <= '0;
            act_blink_q <= '0;
            pend_q      <= 1'b0;
            frm_q       <= '0;
            phase_q     <= 1'b1;
            seg_q       <= SEG_OFF;
            cath_q      <= '1;
            fs_q        <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            sh_code_q   <= sh_code_d;
            sh_dp_q     <= sh_dp_d;
            sh_blink_q  <= sh_blink_d;
            act_code_q  <= act_code_d;
            act_dp_q    <= act_dp_d;
            act_blink_q <= act_blink_d;
            pend_q      <= pend_d;
            frm_q       <= frm_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            cath_q      <= cath_d;
            fs_q        <= fs_d;
            ack_q       <= ack_d;
        end
    end

    assign digit_seg   = seg_q;
    assign digit_cath  = cath_q;
    assign frame_start = fs_q;
    assign load_ack    = ack_q;

endmodule
